// File: rtl/rsa_pkg.sv
// Shared operand geometry for the Montgomery wrapper and its upstream loader.
// RSA_BITS must be an integer multiple of WORD_BITS.
package rsa_pkg;

  localparam int RSA_BITS  = 1024;
  localparam int WORD_BITS = 32;
  localparam int WORDS     = RSA_BITS / WORD_BITS;
  localparam int CNT_W     = $clog2(WORDS) + 1;

  // ASM_RESET keeps in_read low for the first edge after reset release.
  typedef enum logic [1:0] {
    ASM_RESET = 2'd0,
    ASM_FILL  = 2'd1,
    ASM_FULL  = 2'd2
  } asm_state_e;

  function automatic logic cnt_at_last(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(WORDS - 1);
  endfunction

endpackage

// File: rtl/loader_out_slot.sv
// Single-entry output slot: holds one assembled operand plus its valid flag.
// clr beats load, load beats read, so a read on a reload edge keeps valid high.
module loader_out_slot #(
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (rd) begin
      valid <= 1'b0;
    end
  end

  // dout holds its last value after a read so downstream sees no glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (load && !clr) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/operand_stream_loader.sv
// Assembles WORD_BITS host words into one RSA_BITS operand and hands it to the core.
// Word order: LSW first by default; define LOADER_MSW_FIRST_EN for MSW first.
module operand_stream_loader
  import rsa_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic [WORD_BITS-1:0] in_din,
  input  logic                 in_valid,
  output logic                 in_read,
  output logic [RSA_BITS-1:0]  out_dout,
  output logic                 out_valid,
  input  logic                 out_read,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 busy
);

  asm_state_e            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [RSA_BITS-1:0]   asm_reg;
  logic [RSA_BITS-1:0]   asm_shifted;
  logic                  accept;
  logic                  transfer;

  // in_read depends only on registered state and clr, never on in_valid/out_read.
  assign in_read  = (state == ASM_FILL) && !clr;
  assign accept   = in_valid && in_read;
  assign transfer = (state == ASM_FULL) && (!out_valid || out_read) && !clr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ASM_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = ASM_FILL;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ASM_RESET: state_nxt = ASM_FILL;
        ASM_FILL: begin
          if (accept) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt_at_last(cnt)) state_nxt = ASM_FULL;
          end
        end
        ASM_FULL: begin
          if (transfer) begin
            cnt_nxt   = '0;
            state_nxt = ASM_FILL;
          end
        end
        default: begin
          state_nxt = ASM_FILL;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef LOADER_MSW_FIRST_EN
  assign asm_shifted = {asm_reg[RSA_BITS-WORD_BITS-1:0], in_din};
`else
  assign asm_shifted = {in_din, asm_reg[RSA_BITS-1:WORD_BITS]};
`endif

  // Datapath only; a fresh operand always overwrites every word before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      asm_reg <= asm_shifted;
    end
  end

  loader_out_slot #(
    .DATA_W (RSA_BITS)
  ) u_out_slot (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .load   (transfer),
    .din    (asm_reg),
    .rd     (out_read),
    .dout   (out_dout),
    .valid  (out_valid)
  );

  assign word_cnt = cnt;
  assign busy     = (cnt != '0) || out_valid;

endmodule

// File: tb/tb_operand_stream_loader.sv
// Self-checking bench for operand_stream_loader: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_operand_stream_loader;
  import rsa_pkg::*;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 clr = 1'b0;
  logic [WORD_BITS-1:0] in_din = '0;
  logic                 in_valid = 1'b0;
  logic                 in_read;
  logic [RSA_BITS-1:0]  out_dout;
  logic                 out_valid;
  logic                 out_read = 1'b0;
  logic [CNT_W-1:0]     word_cnt;
  logic                 busy;

  operand_stream_loader dut (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr),
    .in_din   (in_din),
    .in_valid (in_valid),
    .in_read  (in_read),
    .out_dout (out_dout),
    .out_valid(out_valid),
    .out_read (out_read),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: accepted words in arrival order, plus the output slot.
  logic [WORD_BITS-1:0] mq[$];
  logic                 m_valid = 1'b0;
  logic [RSA_BITS-1:0]  m_dout = '0;
  logic                 m_started = 1'b0;

  typedef struct {
    logic                 v;
    logic [WORD_BITS-1:0] d;
    logic                 rd;
    logic                 c;
    logic                 e_ir;
    int                   e_cnt;
    logic                 e_ov;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [RSA_BITS-1:0] pack_words(input logic [WORD_BITS-1:0] w[$]);
    logic [RSA_BITS-1:0] r = '0;
    for (int i = 0; i < w.size(); i++) begin
`ifdef LOADER_MSW_FIRST_EN
      r[(WORDS-1-i)*WORD_BITS +: WORD_BITS] = w[i];
`else
      r[i*WORD_BITS +: WORD_BITS] = w[i];
`endif
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_op(input string name, input logic [RSA_BITS-1:0] act,
                        input logic [RSA_BITS-1:0] exp);
    int k;
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      k = 0;
      for (int i = WORDS-1; i >= 0; i--)
        if (act[i*WORD_BITS +: WORD_BITS] !== exp[i*WORD_BITS +: WORD_BITS]) k = i;
      $display("FAIL %s: word %0d got %h expected %h at %0t", name, k,
               act[k*WORD_BITS +: WORD_BITS], exp[k*WORD_BITS +: WORD_BITS], $time);
    end
  endtask

  task automatic model_step(input logic v, input logic [WORD_BITS-1:0] d,
                            input logic rd, input logic c);
    logic full, acc;
    if (c) begin
      mq.delete();
      m_valid = 1'b0;
    end else begin
      full = (mq.size() == WORDS);
      acc  = v && m_started && !full;
      if (full && (!m_valid || rd)) begin
        m_dout  = pack_words(mq);
        m_valid = 1'b1;
        mq.delete();
      end else if (rd && m_valid) begin
        m_valid = 1'b0;
      end
      if (acc) mq.push_back(d);
    end
    m_started = 1'b1;
  endtask

  task automatic check_outputs();
    chk("word_cnt", 64'(word_cnt), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'((mq.size() != 0) || m_valid));
    if (m_valid) chk_op("out_dout", out_dout, m_dout);
  endtask

  task automatic cycle(input logic v, input logic [WORD_BITS-1:0] d,
                       input logic rd, input logic c);
    in_valid = v; in_din = d; out_read = rd; clr = c;
    #1;
    chk("in_read", 64'(in_read), 64'(m_started && (mq.size() < WORDS) && !c));
    @(posedge clk);
    model_step(v, d, rd, c);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst word_cnt", 64'(word_cnt), 64'd0);
    chk("rst in_read", 64'(in_read), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_dout", out_dout[63:0], 64'd0);
    mq.delete();
    m_valid = 1'b0;
    m_dout = '0;
    m_started = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  logic [RSA_BITS-1:0] op_a;
  logic [WORD_BITS-1:0] exp_lo, exp_hi;

  initial begin
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[2] = '{1'b0, 32'hA2, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[3] = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[6] = '{1'b1, 32'hA6, 1'b1, 1'b0, 1'b1, 2, 1'b0};

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v; in_din = tbl[i].d; out_read = tbl[i].rd; clr = tbl[i].c;
      #1;
      chk("tbl in_read", 64'(in_read), 64'(tbl[i].e_ir));
      @(posedge clk);
      model_step(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].c);
      #1;
      chk("tbl word_cnt", 64'(word_cnt), 64'(tbl[i].e_cnt));
      chk("tbl out_valid", 64'(out_valid), 64'(tbl[i].e_ov));
      check_outputs();
    end

    // Basic load, words 0..31 with the consumer always ready.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < WORDS; i++) cycle(1'b1, WORD_BITS'(i), 1'b1, 1'b0);
    chk("basic pre valid", 64'(out_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef LOADER_MSW_FIRST_EN
    exp_lo = 32'h1F; exp_hi = 32'h0;
`else
    exp_lo = 32'h0; exp_hi = 32'h1F;
`endif
    chk("basic out_valid", 64'(out_valid), 64'd1);
    chk("basic low word", 64'(out_dout[WORD_BITS-1:0]), 64'(exp_lo));
    chk("basic high word", 64'(out_dout[RSA_BITS-1 -: WORD_BITS]), 64'(exp_hi));

    // Backpressure: two operands streamed with the consumer stalled.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 70; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("bp word_cnt", 64'(word_cnt), 64'(WORDS));
    chk("bp in_read", 64'(in_read), 64'd0);
    chk("bp out_valid", 64'(out_valid), 64'd1);
    op_a = pack_words(mq);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("simul out_valid", 64'(out_valid), 64'd1);
    chk_op("simul out_dout", out_dout, op_a);
    chk("simul word_cnt", 64'(word_cnt), 64'd0);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);

    // Gapped all-ones input.
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2*WORDS; i++) cycle((i % 2) == 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("gap out_valid", 64'(out_valid), 64'd1);
    chk_op("gap all ones", out_dout, {RSA_BITS{1'b1}});

    // clr with a full slot and a partial operand; the clr-edge word is dropped.
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < WORDS + 1 + 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("pre clr word_cnt", 64'(word_cnt), 64'd10);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("clr out_valid", 64'(out_valid), 64'd0);
    chk("clr word_cnt", 64'(word_cnt), 64'd0);

    // Asynchronous reset in the middle of a load, then a clean reload.
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < WORDS + 2; i++) cycle(1'b1, WORD_BITS'(i + 100), 1'b0, 1'b0);
    chk("post rst out_valid", 64'(out_valid), 64'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 99) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
